regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 127 ++++++++++++
 tb/tb_regfile_sb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/2W register file (core + MAU load port) with load scoreboard.
// Ports: clk/reset, core wr (run_en,rd_en,rd,data_in), MAU wr (rdmau_en,rdmau,
// data_mau_in), reads (rs1/rs2 -> data_out1/2), issue (issue_en,issue_rd),
// status (stall, busy_cnt, waw_err).
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run_en,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] data_in,
  input  logic            rdmau_en,
  input  logic [AW-1:0]   rdmau,
  input  logic [XLEN-1:0] data_mau_in,
  input  logic            rs1_en,
  input  logic [AW-1:0]   rs1,
  input  logic            rs2_en,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] data_out1,
  output logic [XLEN-1:0] data_out2,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  output logic            stall,
  output logic [AW:0]     busy_cnt,
  output logic            waw_err
);

  logic [XLEN-1:0] rf_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            waw_q, waw_d;

  logic core_we, mau_we, iss_we;
  logic ok_rd, ok_mau, ok_iss, ok_rs1, ok_rs2;
  logic stall1, stall2;

  // Index 0 is hardwired zero; indices >= NREG do not exist.
  function automatic logic idx_ok(input logic [AW-1:0] idx);
    return (idx != '0) && ({1'b0, idx} < (AW+1)'(NREG));
  endfunction

  assign ok_rd  = idx_ok(rd);
  assign ok_mau = idx_ok(rdmau);
  assign ok_iss = idx_ok(issue_rd);
  assign ok_rs1 = idx_ok(rs1);
  assign ok_rs2 = idx_ok(rs2);

  assign core_we = run_en & rd_en & ok_rd;
  assign mau_we  = rdmau_en & ok_mau;
  assign iss_we  = issue_en & ok_iss;

  // Read ports: core write has priority over MAU write when forwarding.
  always_comb begin
    data_out1 = '0;
    if (rs1_en && ok_rs1) begin
      if (BYPASS != 0 && core_we && rd == rs1)
        data_out1 = data_in;
      else if (BYPASS != 0 && mau_we && rdmau == rs1)
        data_out1 = data_mau_in;
      else
        data_out1 = rf_q[rs1];
    end
  end

  always_comb begin
    data_out2 = '0;
    if (rs2_en && ok_rs2) begin
      if (BYPASS != 0 && core_we && rd == rs2)
        data_out2 = data_in;
      else if (BYPASS != 0 && mau_we && rdmau == rs2)
        data_out2 = data_mau_in;
      else
        data_out2 = rf_q[rs2];
    end
  end

  // A pending source no longer stalls when its load lands this cycle
  // and the value can be forwarded.
  always_comb begin
    stall1 = rs1_en & ok_rs1 & busy_q[rs1];
    stall2 = rs2_en & ok_rs2 & busy_q[rs2];
    if (BYPASS != 0 && mau_we && rdmau == rs1) stall1 = 1'b0;
    if (BYPASS != 0 && mau_we && rdmau == rs2) stall2 = 1'b0;
  end

  assign stall = stall1 | stall2;

  // Clear then set, so a back-to-back load to the same index stays busy.
  always_comb begin
    busy_d = busy_q;
    if (mau_we) busy_d[rdmau]   = 1'b0;
    if (iss_we) busy_d[issue_rd] = 1'b1;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREG; i++)
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
  end

  assign waw_d = waw_q | (core_we & busy_q[rd]);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
      waw_q  <= 1'b0;
    end else begin
      if (mau_we)  rf_q[rdmau] <= data_mau_in;
      // Later assignment wins: core data beats MAU on the same index.
      if (core_we) rf_q[rd]    <= data_in;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      waw_q  <= waw_d;
    end
  end

  assign busy_cnt = cnt_q;
  assign waw_err  = waw_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vectors for regfile_sb (BYPASS=1 defaults).
// Expected values are hand-computed constants.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_en, rd_en, rdmau_en;
  logic [4:0]  rd, rdmau, rs1, rs2, issue_rd;
  logic [31:0] data_in, data_mau_in;
  logic        rs1_en, rs2_en, issue_en;
  logic [31:0] data_out1, data_out2;
  logic        stall, waw_err;
  logic [5:0]  busy_cnt;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .reset(reset),
    .run_en(run_en), .rd_en(rd_en), .rd(rd), .data_in(data_in),
    .rdmau_en(rdmau_en), .rdmau(rdmau), .data_mau_in(data_mau_in),
    .rs1_en(rs1_en), .rs1(rs1), .rs2_en(rs2_en), .rs2(rs2),
    .data_out1(data_out1), .data_out2(data_out2),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .stall(stall), .busy_cnt(busy_cnt), .waw_err(waw_err)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 0; run_en = 0; rd_en = 0; rd = 0; data_in = 0;
    rdmau_en = 0; rdmau = 0; data_mau_in = 0;
    rs1_en = 0; rs1 = 0; rs2_en = 0; rs2 = 0;
    issue_en = 0; issue_rd = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cwr(input logic [4:0] i, input logic [31:0] d);
    run_en = 1; rd_en = 1; rd = i; data_in = d;
  endtask

  task automatic mwr(input logic [4:0] i, input logic [31:0] d);
    rdmau_en = 1; rdmau = i; data_mau_in = d;
  endtask

  task automatic rd1(input logic [4:0] i);
    rs1_en = 1; rs1 = i;
  endtask

  task automatic rd2(input logic [4:0] i);
    rs2_en = 1; rs2 = i;
  endtask

  initial begin
    idle();
    reset = 1;
    step(); step();
    idle();
    #1;
    chk("rst_cnt", busy_cnt, 0);
    chk("rst_waw", waw_err, 0);
    rd1(5); #1;
    chk("rst_x5", data_out1, 0);
    chk("rst_stall", stall, 0);

    // core write gated by run_en
    idle(); cwr(5, 32'hDEADBEEF); rd1(5); #1;
    chk("byp_core", data_out1, 32'hDEADBEEF);
    step();
    idle(); rd1(5); #1;
    chk("x5_wr", data_out1, 32'hDEADBEEF);
    cwr(5, 32'h1); run_en = 0; #1;
    chk("x5_noby", data_out1, 32'hDEADBEEF);
    step();
    idle(); rd1(5); #1;
    chk("x5_gated", data_out1, 32'hDEADBEEF);

    // MAU not gated by run_en
    idle(); mwr(6, 32'h66); step();
    idle(); rd1(6); #1;
    chk("x6_mau", data_out1, 32'h66);

    // same-index conflict: core wins
    idle(); cwr(7, 32'h11); mwr(7, 32'h22); rd2(7); #1;
    chk("conf_byp", data_out2, 32'h11);
    step();
    idle(); rd2(7); #1;
    chk("conf_wr", data_out2, 32'h11);

    // different indices both written
    idle(); cwr(8, 32'h88); mwr(10, 32'hAA); step();
    idle(); rd1(8); rd2(10); #1;
    chk("dual_c", data_out1, 32'h88);
    chk("dual_m", data_out2, 32'hAA);

    // scoreboard: issue, stall, load lands
    idle(); issue_en = 1; issue_rd = 3; step();
    idle(); rd1(3); #1;
    chk("iss_cnt", busy_cnt, 1);
    chk("iss_stall", stall, 1);
    mwr(3, 32'hAB); #1;
    chk("land_stall", stall, 0);
    chk("land_byp", data_out1, 32'hAB);
    step();
    idle(); rd1(3); #1;
    chk("land_cnt", busy_cnt, 0);
    chk("land_nost", stall, 0);
    chk("land_x3", data_out1, 32'hAB);

    // back-to-back load: set beats clear
    idle(); issue_en = 1; issue_rd = 4; mwr(4, 32'h44); step();
    idle(); rd2(4); #1;
    chk("b2b_cnt", busy_cnt, 1);
    chk("b2b_stall", stall, 1);
    issue_en = 1; issue_rd = 4; step();
    idle(); #1;
    chk("reiss_cnt", busy_cnt, 1);
    issue_en = 1; issue_rd = 11; step();
    idle(); #1;
    chk("two_cnt", busy_cnt, 2);
    mwr(4, 32'h45); step();
    mwr(11, 32'h0); step();
    idle(); #1;
    chk("clr_cnt", busy_cnt, 0);

    // WAW on pending register
    idle(); issue_en = 1; issue_rd = 9; step();
    idle(); cwr(9, 32'h99); #1;
    chk("waw_pre", waw_err, 0);
    step();
    idle(); #1;
    chk("waw_set", waw_err, 1);
    chk("waw_cnt", busy_cnt, 1);
    step(); step();
    chk("waw_hold", waw_err, 1);

    // reset cancels everything; discards same-cycle write
    reset = 1; cwr(12, 32'hC); issue_en = 1; issue_rd = 13; step();
    idle(); rd1(9); rd2(12); #1;
    chk("r2_waw", waw_err, 0);
    chk("r2_cnt", busy_cnt, 0);
    chk("r2_x9", data_out1, 0);
    chk("r2_x12", data_out2, 0);
    chk("r2_stall", stall, 0);

    // first edge after reset accepts; late MAU write no underflow
    idle(); cwr(12, 32'h1212); mwr(9, 32'h909); step();
    idle(); rd1(9); rd2(12); #1;
    chk("post_x9", data_out1, 32'h909);
    chk("post_x12", data_out2, 32'h1212);
    chk("post_cnt", busy_cnt, 0);

    // x0 hardwired
    idle(); cwr(0, 32'hFFFFFFFF); mwr(0, 32'hFFFFFFFF);
    issue_en = 1; issue_rd = 0; rd1(0); rd2(0); #1;
    chk("x0_o1", data_out1, 0);
    chk("x0_o2", data_out2, 0);
    chk("x0_st", stall, 0);
    step();
    idle(); rd1(0); rd2(0); #1;
    chk("x0_cnt", busy_cnt, 0);
    chk("x0_r1", data_out1, 0);
    chk("x0_r2", data_out2, 0);

    // disabled port reads 0
    idle(); rs1 = 5; rs1_en = 0; #1;
    chk("dis_rd", data_out1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
